// File: rtl/store_buffer_if.sv
// Signal bundle between the MEM-stage pipeline, the store buffer and the data memory.
// The buffer takes the slave view; the pipeline/memory environment takes the master view.
interface store_buffer_if #(
    parameter int DEPTH = 4,
    parameter int AW    = 32,
    parameter int DW    = 32
);
    logic                       st_valid;
    logic [AW-1:0]              st_addr;
    logic [DW-1:0]              st_data;
    logic                       ld_valid;
    logic [AW-1:0]              ld_addr;
    logic [DW-1:0]              ld_data;
    logic                       stall;
    logic                       mem_ready;
    logic                       mem_wr;
    logic                       mem_rd;
    logic [AW-1:0]              mem_addr;
    logic [DW-1:0]              mem_wdata;
    logic [DW-1:0]              mem_rdata;
    logic                       empty;
    logic [$clog2(DEPTH+1)-1:0] count;

    modport slave (
        input  st_valid, st_addr, st_data, ld_valid, ld_addr, mem_ready, mem_rdata,
        output ld_data, stall, mem_wr, mem_rd, mem_addr, mem_wdata, empty, count
    );

    modport master (
        output st_valid, st_addr, st_data, ld_valid, ld_addr, mem_ready, mem_rdata,
        input  ld_data, stall, mem_wr, mem_rd, mem_addr, mem_wdata, empty, count
    );
endinterface

// File: rtl/store_buffer.sv
// Posted-write store FIFO in front of the data memory: loads own the address port,
// stores drain in order whenever the write port is granted, loads forward from the youngest match.
module store_buffer #(
    parameter int DEPTH = 4,
    parameter int AW    = 32,
    parameter int DW    = 32,
    parameter int IDX_W = 5
) (
    input  logic          clk,
    input  logic          reset,
    store_buffer_if.slave sb
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [PW-1:0] LAST_C  = PW'(DEPTH - 1);

    logic [AW-1:0]    addr_r [DEPTH];
    logic [DW-1:0]    data_r [DEPTH];
    logic [DEPTH-1:0] valid_r;
    logic [PW-1:0]    head_r;
    logic [PW-1:0]    tail_r;
    logic [CW-1:0]    count_r;

    logic             full_s;
    logic             empty_s;
    logic             stall_s;
    logic             accept_s;
    logic             drain_s;
    logic [PW-1:0]    scan_idx_s;
    logic [DW-1:0]    fwd_data_s;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        ptr_inc = (p == LAST_C) ? {PW{1'b0}} : p + PW'(1);
    endfunction

    // Occupancy flags and per-cycle handshake decisions from registered state
    always_comb begin
        full_s   = (count_r == DEPTH_C);
        empty_s  = (count_r == {CW{1'b0}});
        stall_s  = ~reset & sb.st_valid & (full_s | sb.ld_valid);
        accept_s = ~reset & sb.st_valid & ~full_s & ~sb.ld_valid;
        drain_s  = ~reset & sb.mem_ready & ~sb.ld_valid & ~empty_s;
    end

    // Pointers, entry valid bits and occupancy count
    always_ff @(posedge clk) begin
        if (reset) begin
            head_r  <= {PW{1'b0}};
            tail_r  <= {PW{1'b0}};
            count_r <= {CW{1'b0}};
            valid_r <= {DEPTH{1'b0}};
        end else begin
            // accept writes at tail, drain retires head; they never hit the same slot in one cycle
            if (accept_s) begin
                valid_r[tail_r] <= 1'b1;
                tail_r          <= ptr_inc(tail_r);
            end
            if (drain_s) begin
                valid_r[head_r] <= 1'b0;
                head_r          <= ptr_inc(head_r);
            end
            case ({accept_s, drain_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Entry payload storage; contents are meaningless while the valid bit is clear
    always_ff @(posedge clk) begin
        if (accept_s) begin
            addr_r[tail_r] <= sb.st_addr;
            data_r[tail_r] <= sb.st_data;
        end else begin
            addr_r[tail_r] <= addr_r[tail_r];
            data_r[tail_r] <= data_r[tail_r];
        end
    end

    // Forwarding scan from oldest to youngest occupied slot so the youngest match wins
    always_comb begin
        fwd_data_s = sb.mem_rdata;
        scan_idx_s = {PW{1'b0}};
        for (int k = DEPTH - 1; k >= 0; k--) begin
            scan_idx_s = PW'((int'(tail_r) + DEPTH - 1 - k) % DEPTH);
            fwd_data_s = ((k < int'(count_r)) && valid_r[scan_idx_s] &&
                          (addr_r[scan_idx_s][IDX_W-1:0] == sb.ld_addr[IDX_W-1:0]))
                         ? data_r[scan_idx_s] : fwd_data_s;
        end
    end

    // Shared memory port: load first, then drain, otherwise quiet
    always_comb begin
        sb.mem_rd    = 1'b0;
        sb.mem_wr    = 1'b0;
        sb.mem_addr  = {AW{1'b0}};
        sb.mem_wdata = {DW{1'b0}};
        if (sb.ld_valid) begin
            sb.mem_rd   = 1'b1;
            sb.mem_addr = sb.ld_addr;
        end else if (drain_s) begin
            sb.mem_wr    = 1'b1;
            sb.mem_addr  = addr_r[head_r];
            sb.mem_wdata = data_r[head_r];
        end else begin
            sb.mem_rd    = 1'b0;
            sb.mem_wr    = 1'b0;
            sb.mem_addr  = {AW{1'b0}};
            sb.mem_wdata = {DW{1'b0}};
        end
    end

    assign sb.ld_data = fwd_data_s;
    assign sb.stall   = stall_s;
    assign sb.empty   = empty_s;
    assign sb.count   = count_r;

endmodule
